// File: rtl/apb_slave_regfile.sv
// APB slave exposing NUM_REGS byte-strobed registers, with a fixed number of
// wait states per transfer and an error response for unmapped or misaligned addresses.
module apb_slave_regfile #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_STATES = 2
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    PSELx,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic                    PREADY,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PSLVERR
);

   localparam int STRB_W    = DATA_WIDTH / 8;
   localparam int LANE_BITS = (STRB_W > 1) ? $clog2(STRB_W) : 0;
   localparam int WCNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam int RIDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [ADDR_WIDTH-1:0] LANE_MASK  = ADDR_WIDTH'((1 << LANE_BITS) - 1);
   localparam logic [ADDR_WIDTH:0]   NUM_REGS_V = (ADDR_WIDTH + 1)'(NUM_REGS);
   localparam logic [WCNT_W-1:0]     WCNT_LOAD  = WCNT_W'(WAIT_STATES);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t                  state;
   logic [WCNT_W-1:0]       wcnt;
   logic [ADDR_WIDTH-1:0]   hold_addr;
   logic                    hold_write;
   logic [DATA_WIDTH-1:0]   hold_wdata;
   logic [STRB_W-1:0]       hold_strb;
   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

   logic [ADDR_WIDTH-1:0]   index_full;
   logic [RIDX_W-1:0]       reg_idx;
   logic                    addr_valid;
   logic                    done;
   logic                    do_write;

   // Decode works only on the captured address so bus changes mid-transfer have no effect.
   assign index_full = hold_addr >> LANE_BITS;
   assign reg_idx    = index_full[RIDX_W-1:0];
   assign addr_valid = ((hold_addr & LANE_MASK) == '0) && ({1'b0, index_full} < NUM_REGS_V);

   assign done     = (state == ACCESS) && (wcnt == '0);
   assign do_write = done && PSELx && hold_write && addr_valid;

   assign PREADY  = done;
   assign PSLVERR = done && !addr_valid;
   assign PRDATA  = (done && !hold_write && addr_valid) ? regs[reg_idx] : '0;

   // Transfer sequencing: a setup cycle loads the wait counter and captures the request;
   // dropping PSELx during the access phase abandons the transfer.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state      <= IDLE;
         wcnt       <= '0;
         hold_addr  <= '0;
         hold_write <= 1'b0;
         hold_wdata <= '0;
         hold_strb  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (PSELx && !PENABLE) begin
                  state      <= ACCESS;
                  wcnt       <= WCNT_LOAD;
                  hold_addr  <= PADDR;
                  hold_write <= PWRITE;
                  hold_wdata <= PWDATA;
                  hold_strb  <= PSTRB;
               end
            end
            ACCESS: begin
               if (!PSELx) begin
                  state <= IDLE;
                  wcnt  <= '0;
               end else if (wcnt == '0) begin
                  state <= IDLE;
               end else if (PENABLE) begin
                  wcnt <= wcnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               wcnt  <= '0;
            end
         endcase
      end
   end

   // Register file: byte lanes update only on the completion edge of a valid write.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else if (do_write) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (hold_strb[b]) begin
               regs[reg_idx][8*b +: 8] <= hold_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a table of APB transfers with hand-computed
// responses, followed by abort, stray-enable and mid-transfer reset sequences.
module tb_apb_slave_regfile;

   localparam int WS       = 2;
   localparam int XFER_CYC = 2 + WS;
   localparam int NVEC     = 16;

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic        pclk;
   logic        preset;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   int checks = 0;
   int errors = 0;

   vec_t        vecs [NVEC];
   logic [31:0] exp_regs [16];

   apb_slave_regfile #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (32),
      .NUM_REGS   (16),
      .WAIT_STATES(WS)
   ) dut (
      .PCLK   (pclk),
      .PRESET (preset),
      .PSELx  (psel),
      .PENABLE(penable),
      .PWRITE (pwrite),
      .PADDR  (paddr),
      .PWDATA (pwdata),
      .PSTRB  (pstrb),
      .PREADY (pready),
      .PRDATA (prdata),
      .PSLVERR(pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // One complete transfer starting with a setup cycle; the access phase drives
   // scrambled bus values that the slave must ignore.
   task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                                output int cycles, output logic timed_out, output logic early_err);
      logic finished;
      @(posedge pclk); #1;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      pstrb   = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      pwrite  = ~wr;
      paddr   = ~addr;
      pwdata  = ~wdata;
      pstrb   = ~strb;
      cycles    = 2;
      timed_out = 1'b0;
      early_err = 1'b0;
      rdata     = '0;
      err       = 1'b0;
      finished  = 1'b0;
      while (!finished) begin
         @(negedge pclk);
         if (pready) begin
            rdata    = prdata;
            err      = pslverr;
            finished = 1'b1;
         end else begin
            if (pslverr) early_err = 1'b1;
            if (cycles >= 20) begin
               timed_out = 1'b1;
               finished  = 1'b1;
            end else begin
               @(posedge pclk); #1;
               cycles++;
            end
         end
      end
   endtask

   task automatic goIdle();
      @(posedge pclk); #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic doCheckedXfer(input string tag, input logic wr, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic [31:0] exp_rdata, input logic exp_err);
      logic [31:0] rdata;
      logic        err;
      logic        timed_out;
      logic        early_err;
      int          cycles;
      applyStimulus(wr, addr, wdata, strb, rdata, err, cycles, timed_out, early_err);
      checkOutput({tag, " timeout"}, 32'(timed_out), 32'd0);
      checkOutput({tag, " cycles"}, 32'(cycles), 32'(XFER_CYC));
      checkOutput({tag, " pslverr"}, 32'(err), 32'(exp_err));
      checkOutput({tag, " prdata"}, rdata, exp_rdata);
      checkOutput({tag, " early pslverr"}, 32'(early_err), 32'd0);
   endtask

   initial begin
      logic seen_ready;

      vecs[0]  = '{1'b0, 8'h08, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b1, 8'h08, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
      vecs[2]  = '{1'b0, 8'h08, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b1, 8'h04, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
      vecs[5]  = '{1'b0, 8'h04, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0};
      vecs[6]  = '{1'b1, 8'h3C, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
      vecs[7]  = '{1'b0, 8'h3C, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b0};
      vecs[8]  = '{1'b0, 8'h40, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b1, 8'h05, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
      vecs[10] = '{1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
      vecs[11] = '{1'b1, 8'h0C, 32'h0102_0304, 4'h0, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 8'h0C, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b0};
      vecs[13] = '{1'b1, 8'h10, 32'hCAFE_F00D, 4'h9, 32'h0000_0000, 1'b0};
      vecs[14] = '{1'b0, 8'h10, 32'h0000_0000, 4'hF, 32'hCA00_000D, 1'b0};
      vecs[15] = '{1'b0, 8'h06, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};

      for (int r = 0; r < 16; r++) exp_regs[r] = 32'h0;
      exp_regs[1]  = 32'hDE22_BE44;
      exp_regs[4]  = 32'hCA00_000D;
      exp_regs[15] = 32'hA5A5_A5A5;

      preset  = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      repeat (3) @(posedge pclk);
      #1 preset = 1'b0;
      @(negedge pclk);
      checkOutput("reset pready", 32'(pready), 32'd0);
      checkOutput("reset pslverr", 32'(pslverr), 32'd0);
      checkOutput("reset prdata", prdata, 32'd0);

      // Table transfers run back to back with no idle cycle between them.
      for (int i = 0; i < NVEC; i++) begin
         doCheckedXfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                       vecs[i].strb, vecs[i].exp_rdata, vecs[i].exp_err);
      end

      for (int r = 0; r < 16; r++) begin
         doCheckedXfer($sformatf("reread%0d", r), 1'b0, 8'(r * 4), 32'h0, 4'hF, exp_regs[r], 1'b0);
      end

      // Enable without a setup cycle must not start a transfer.
      goIdle();
      @(posedge pclk); #1;
      psel    = 1'b1;
      penable = 1'b1;
      pwrite  = 1'b1;
      paddr   = 8'h20;
      pwdata  = 32'h5555_AAAA;
      pstrb   = 4'hF;
      seen_ready = 1'b0;
      repeat (4) begin
         @(negedge pclk);
         if (pready) seen_ready = 1'b1;
      end
      checkOutput("stray enable pready", 32'(seen_ready), 32'd0);
      goIdle();
      doCheckedXfer("stray enable read", 1'b0, 8'h20, 32'h0, 4'hF, 32'h0, 1'b0);

      // Deselect during the first access cycle abandons the write.
      goIdle();
      @(posedge pclk); #1;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h00;
      pwdata  = 32'hFFFF_FFFF;
      pstrb   = 4'hF;
      @(posedge pclk); #1;
      psel    = 1'b0;
      penable = 1'b1;
      seen_ready = 1'b0;
      repeat (6) begin
         @(negedge pclk);
         if (pready) seen_ready = 1'b1;
      end
      checkOutput("abort pready", 32'(seen_ready), 32'd0);
      penable = 1'b0;
      doCheckedXfer("abort read", 1'b0, 8'h00, 32'h0, 4'hF, 32'h0, 1'b0);

      // Reset arriving in the last wait cycle must win over completion.
      goIdle();
      @(posedge pclk); #1;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h10;
      pwdata  = 32'h1234_5678;
      pstrb   = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b1;
      @(posedge pclk); #1;
      preset  = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge pclk);
      checkOutput("midreset pready", 32'(pready), 32'd0);
      checkOutput("midreset pslverr", 32'(pslverr), 32'd0);
      checkOutput("midreset prdata", prdata, 32'd0);
      doCheckedXfer("midreset read10", 1'b0, 8'h10, 32'h0, 4'hF, 32'h0, 1'b0);
      doCheckedXfer("midreset read04", 1'b0, 8'h04, 32'h0, 4'hF, 32'h0, 1'b0);
      doCheckedXfer("post reset write", 1'b1, 8'h10, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
      doCheckedXfer("post reset read", 1'b0, 8'h10, 32'h0, 4'hF, 32'h1234_5678, 1'b0);
      goIdle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
